// File: rtl/sequential_divider_if.sv
// sequential_divider_if: start/done handshake, operands and results of the divider
interface sequential_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signedOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             divByZero;
  logic             overflow;
  modport master (output start, signedOp, a, b, input busy, done, Q, R, divByZero, overflow);
  modport slave (input start, signedOp, a, b, output busy, done, Q, R, divByZero, overflow);
endinterface

// File: rtl/sequential_divider.sv
// sequential_divider: restoring shift-and-subtract divider, one quotient bit per clock
module sequential_divider #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  sequential_divider_if.slave dif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH:0]   shifted, diff;
  logic             accept, neg_a, neg_b;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign accept  = dif.start && (state_q == IDLE || state_q == DONE);
  assign neg_a   = dif.signedOp & dif.a[WIDTH-1];
  assign neg_b   = dif.signedOp & dif.b[WIDTH-1];
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    ovf_pend_d = ovf_pend_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    if (accept && dif.b == '0) begin
      q_d     = '1;
      r_d     = dif.a;
      dbz_d   = 1'b1;
      ovf_d   = 1'b0;
      state_d = DONE;
    end else if (accept) begin
      quo_d      = neg_a ? -dif.a : dif.a;
      div_d      = neg_b ? -dif.b : dif.b;
      rem_d      = '0;
      cnt_d      = '0;
      qneg_d     = neg_a ^ neg_b;
      rneg_d     = neg_a;
      ovf_pend_d = dif.signedOp && dif.a == {1'b1, {(WIDTH-1){1'b0}}} && dif.b == '1;
      state_d    = RUN;
    end else if (state_q == RUN) begin
      // a borrow out of the trial subtract means the divisor did not fit: restore
      rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d   = cnt_q + CW'(1);
      state_d = cnt_q == CW'(WIDTH-1) ? FIX : RUN;
    end else if (state_q == FIX) begin
      q_d     = qneg_q ? -quo_q : quo_q;
      r_d     = rneg_q ? -rem_q : rem_q;
      dbz_d   = 1'b0;
      ovf_d   = ovf_pend_q;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      ovf_pend_q <= ovf_pend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end
  assign dif.busy      = state_q == RUN || state_q == FIX;
  assign dif.done      = state_q == DONE;
  assign dif.Q         = q_q;
  assign dif.R         = r_q;
  assign dif.divByZero = dbz_q;
  assign dif.overflow  = ovf_q;
endmodule
